// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types for the register-file write-back arbiter
package wb_pkg;

  localparam int WB_REGBITS = 5;
  localparam int WB_LOGSIZE = 64;

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } wb_state_e;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_ALU  = 2'd1,
    G_MEM  = 2'd2
  } wb_grant_e;

  typedef struct packed {
    logic [WB_REGBITS-1:0] rd;
    logic [WB_LOGSIZE-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_alu_fifo.sv
// rtl/wb_alu_fifo.sv - small FIFO buffering ALU results awaiting the write port
module wb_alu_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_req_t                  push_req,
  input  logic                     pop,
  output wb_req_t                  head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  wb_req_t         mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO refuses pushes even when it is popped in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_req;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write port arbiter: loads first, ALU results
// buffered, with a starvation limit that forces an ALU drain.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int REGBITS    = WB_REGBITS,
  parameter int LOGSIZE    = WB_LOGSIZE,
  parameter int ALU_DEPTH  = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           alu_valid,
  output logic                           alu_ready,
  input  logic [REGBITS-1:0]             alu_rd,
  input  logic [LOGSIZE-1:0]             alu_data,
  input  logic                           mem_valid,
  output logic                           mem_ready,
  input  logic [REGBITS-1:0]             mem_rd,
  input  logic [LOGSIZE-1:0]             mem_data,
  output logic                           rf_we,
  output logic [REGBITS-1:0]             rf_waddr,
  output logic [LOGSIZE-1:0]             rf_wdata,
  output logic [$clog2(ALU_DEPTH):0]     alu_count
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  wb_state_e  state;
  wb_state_e  state_next;
  logic [SW-1:0] starve_cnt;
  logic [SW-1:0] starve_next;
  wb_grant_e  grant;
  wb_req_t    head;
  wb_req_t    push_req;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;

  assign alu_ready = !fifo_full;
  assign mem_ready = (state == NORMAL);
  assign push      = alu_valid && !fifo_full;
  assign pop       = (grant == G_ALU);
  assign push_req  = '{rd: alu_rd, data: alu_data};

  wb_alu_fifo #(
    .DEPTH (ALU_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_req (push_req),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (alu_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= NORMAL;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

  always_comb begin
    grant       = G_NONE;
    state_next  = state;
    starve_next = starve_cnt;
    case (state)
      NORMAL: begin
        if (mem_valid) begin
          grant = G_MEM;
        end else if (!fifo_empty) begin
          grant = G_ALU;
        end
        // Only a load that wins over waiting ALU work counts as a lost cycle.
        if (!fifo_empty && grant == G_MEM) begin
          if (starve_cnt == SW'(STARVE_MAX - 1)) begin
            starve_next = '0;
            state_next  = FORCE;
          end else begin
            starve_next = starve_cnt + SW'(1);
          end
        end else begin
          starve_next = '0;
        end
      end
      FORCE: begin
        grant       = fifo_empty ? G_NONE : G_ALU;
        state_next  = NORMAL;
        starve_next = '0;
      end
      default: begin
        state_next  = NORMAL;
        starve_next = '0;
      end
    endcase
  end

  // x0 writes still consume their grant but never reach the register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      case (grant)
        G_MEM: begin
          rf_we    <= (mem_rd != '0);
          rf_waddr <= mem_rd;
          rf_wdata <= mem_data;
        end
        G_ALU: begin
          rf_we    <= (head.rd != '0);
          rf_waddr <= head.rd;
          rf_wdata <= head.data;
        end
        default: begin
          rf_we <= 1'b0;
        end
      endcase
    end
  end

endmodule
